// File: rtl/gpio_write_ctrl.sv
// gpio_write_ctrl: AXI-lite write slave feeding a one-hot GPIO register decoder (AW/W/B channels in, wr_en/wr_sel/wr_data out)
module gpio_write_ctrl #(
    parameter int ADDR_W = 32,
    parameter int NREG   = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_W-1:0]       AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    output logic                    wr_en,
    output logic [$clog2(NREG)-1:0] wr_sel,
    output logic [31:0]             wr_data
);
    localparam int SEL_W = $clog2(NREG);
    localparam int AL = SEL_W + 2;
    typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, COMMIT, RESP} state_t;
    state_t state, state_nxt;
    logic aw_hs, w_hs, go, ok;
    logic [AL-1:0] addr_q, addr_nxt;
    logic [31:0] data_q, data_nxt;
    logic [3:0] strb_q, strb_nxt;
    logic unused_addr;
    assign unused_addr = ^AWADDR[ADDR_W-1:AL];
    // ready is gated by resetn so it drops immediately while reset is held
    assign AWREADY = resetn && (state == IDLE || state == WAIT_AW);
    assign WREADY = resetn && (state == IDLE || state == WAIT_W);
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs = WVALID && WREADY;
    assign addr_nxt = aw_hs ? AWADDR[AL-1:0] : addr_q;
    assign data_nxt = w_hs ? WDATA : data_q;
    assign strb_nxt = w_hs ? WSTRB : strb_q;
    assign go = state_nxt == COMMIT;
    assign ok = addr_nxt[1:0] == 2'b00 && |strb_nxt;
    assign BVALID = state == RESP;
    assign BRESP = (state == RESP && addr_q[1:0] != 2'b00) ? 2'b10 : 2'b00;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (aw_hs && w_hs) ? COMMIT : aw_hs ? WAIT_W : w_hs ? WAIT_AW : IDLE;
            WAIT_W:  state_nxt = w_hs ? COMMIT : WAIT_W;
            WAIT_AW: state_nxt = aw_hs ? COMMIT : WAIT_AW;
            COMMIT:  state_nxt = RESP;
            RESP:    state_nxt = BREADY ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    // decoder outputs load on the edge into COMMIT, and only for a real write, so they hold otherwise
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            strb_q <= strb_nxt;
            wr_en  <= go && ok;
            if (go && ok) begin
                wr_sel  <= addr_nxt[AL-1:2];
                wr_data <= data_nxt;
            end
        end
    end
endmodule

// File: tb/tb_gpio_write_ctrl.sv
// tb_gpio_write_ctrl: directed table, reset corner cases and randomized transactions against a reference model
module tb_gpio_write_ctrl;
    logic clock = 0, resetn = 0, AWVALID = 0, WVALID = 0, BREADY = 0;
    logic [31:0] AWADDR = 0, WDATA = 0;
    logic [3:0] WSTRB = 0;
    logic AWREADY, WREADY, BVALID, wr_en;
    logic [1:0] BRESP;
    logic [2:0] wr_sel;
    logic [31:0] wr_data;
    int tests = 0, fails = 0;
    logic [2:0] held_sel = 0;
    logic [31:0] held_data = 0;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic        en;
        logic [2:0]  sel;
        logic [1:0]  resp;
    } vec_t;
    gpio_write_ctrl #(.ADDR_W(32), .NREG(8)) dut (
        .clock(clock), .resetn(resetn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data)
    );
    always #5 clock = ~clock;
    initial begin
        #400000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, " wr_en idle"}, wr_en, 0);
        chk({tag, " wr_sel held"}, wr_sel, held_sel);
        chk({tag, " wr_data held"}, wr_data, held_data);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, " awready"}, AWREADY, 0);
        chk({tag, " wready"}, WREADY, 0);
        chk({tag, " bvalid"}, BVALID, 0);
        chk({tag, " bresp"}, BRESP, 0);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_sel"}, wr_sel, 0);
        chk({tag, " wr_data"}, wr_data, 0);
    endtask
    function automatic vec_t model(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                   input int aw_d, input int w_d, input int b_d);
        vec_t v;
        v.addr = addr; v.data = data; v.strb = strb;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
        v.en = (addr % 4 == 0) && (strb != 0);
        v.sel = 3'((addr % 32) / 4);
        v.resp = (addr % 4 != 0) ? 2'b10 : 2'b00;
        return v;
    endfunction
    task automatic run_txn(input vec_t v, input string tag);
        int cyc = 0;
        bit aw_done = 0, w_done = 0;
        BREADY = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            AWVALID = !aw_done && cyc >= v.aw_d;
            AWADDR = v.addr;
            WVALID = !w_done && cyc >= v.w_d;
            WDATA = v.data;
            WSTRB = v.strb;
            @(negedge clock);
            chk({tag, " awready"}, AWREADY, !aw_done);
            chk({tag, " wready"}, WREADY, !w_done);
            chk_quiet(tag);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            @(posedge clock); #1;
            cyc++;
        end
        AWVALID = 0;
        WVALID = 0;
        if (!(aw_done && w_done)) begin
            tests++; fails++;
            $display("FAIL %s handshake timeout: aw_done %0d w_done %0d required both 1", tag, aw_done, w_done);
            return;
        end
        @(negedge clock);
        chk({tag, " commit wr_en"}, wr_en, v.en);
        if (v.en) begin
            chk({tag, " commit wr_sel"}, wr_sel, v.sel);
            chk({tag, " commit wr_data"}, wr_data, v.data);
            held_sel = v.sel;
            held_data = v.data;
        end else begin
            chk({tag, " commit wr_sel held"}, wr_sel, held_sel);
        end
        chk({tag, " commit ready"}, {AWREADY, WREADY, BVALID}, 0);
        @(posedge clock); #1;
        for (int i = 0; i < v.b_d; i++) begin
            AWVALID = 1; WVALID = 1; AWADDR = $urandom; WDATA = $urandom; WSTRB = 4'hF;
            @(negedge clock);
            chk({tag, " stall bvalid"}, BVALID, 1);
            chk({tag, " stall bresp"}, BRESP, v.resp);
            chk({tag, " stall ready"}, {AWREADY, WREADY}, 0);
            chk_quiet({tag, " stall"});
            @(posedge clock); #1;
        end
        AWVALID = 0; WVALID = 0; BREADY = 1;
        @(negedge clock);
        chk({tag, " bvalid"}, BVALID, 1);
        chk({tag, " bresp"}, BRESP, v.resp);
        chk_quiet({tag, " resp"});
        @(posedge clock); #1;
        BREADY = 0;
    endtask
    initial begin
        vec_t tbl[16];
        vec_t v;
        tbl[0] = '{32'h0C, 32'hA5, 4'hF, 0, 0, 0, 1'b1, 3'd3, 2'b00};
        tbl[1] = '{32'h1C, 32'h3C, 4'hF, 3, 0, 0, 1'b1, 3'd7, 2'b00};
        tbl[2] = '{32'h06, 32'h11, 4'hF, 0, 0, 0, 1'b0, 3'd1, 2'b10};
        tbl[3] = '{32'h04, 32'h22, 4'h0, 0, 0, 0, 1'b0, 3'd1, 2'b00};
        tbl[4] = '{32'h10, 32'h55, 4'h1, 1, 0, 5, 1'b1, 3'd4, 2'b00};
        tbl[5] = '{32'h13, 32'h66, 4'hF, 0, 2, 5, 1'b0, 3'd4, 2'b10};
        for (int a = 0; a < 9; a++)
            tbl[6 + a] = '{32'(a * 4), 32'(256 + a), 4'hF, a % 3, (a + 1) % 3, 0, 1'b1, 3'(a % 8), 2'b00};
        tbl[15] = '{32'hFFFFFFEC, 32'hDEADBEEF, 4'h8, 0, 0, 1, 1'b1, 3'd3, 2'b00};
        repeat (2) @(negedge clock);
        chk_reset("in reset");
        #2 resetn = 1;
        @(negedge clock);
        chk("post-reset ready", {AWREADY, WREADY}, 2'b11);
        @(posedge clock); #1;
        for (int i = 0; i < 16; i++) run_txn(tbl[i], $sformatf("vec%0d", i));
        // reset while waiting for W
        AWVALID = 1; AWADDR = 32'h08;
        @(negedge clock);
        chk("rstw aw ready", AWREADY, 1);
        @(posedge clock); #1;
        AWVALID = 0;
        @(negedge clock);
        chk("rstw wait_w ready", {AWREADY, WREADY}, 2'b01);
        #2 resetn = 0;
        #1 chk_reset("rstw");
        held_sel = 0; held_data = 0;
        @(posedge clock); @(negedge clock);
        chk_reset("rstw held");
        resetn = 1;
        #1 chk("rstw release ready", {AWREADY, WREADY, wr_en}, 3'b110);
        @(posedge clock); #1;
        run_txn(model(32'h14, 32'hBEEF, 4'hF, 0, 1, 0), "after rstw");
        // reset while in RESP
        AWVALID = 1; WVALID = 1; AWADDR = 32'h08; WDATA = 32'h77; WSTRB = 4'hF; BREADY = 0;
        @(posedge clock); #1;
        AWVALID = 0; WVALID = 0;
        @(negedge clock);
        chk("rstb commit wr_en", wr_en, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("rstb bvalid", BVALID, 1);
        #2 resetn = 0;
        #1 chk_reset("rstb");
        held_sel = 0; held_data = 0;
        @(posedge clock); @(negedge clock);
        chk_reset("rstb held");
        resetn = 1;
        @(posedge clock); #1;
        run_txn(model(32'h18, 32'hCAFE, 4'h3, 2, 0, 1), "after rstb");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            logic [3:0] strb;
            addr = $urandom;
            if ($urandom_range(1, 0) == 1) addr = addr & 32'hFFFFFFFC;
            strb = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
            v = model(addr, $urandom, strb, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0));
            run_txn(v, $sformatf("rand%0d", i));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
